// File: rtl/conv_channel_in_acc_ctrl_if.sv
// conv_channel_in_acc_ctrl_if: control and handshake bundle between
// the accumulation controller and its datapath/environment.
interface conv_channel_in_acc_ctrl_if;
  logic start;
  logic busy;
  logic done;
  logic in_valid;
  logic in_ready;
  logic psum_empty;
  logic psum_rd_en;
  logic acc_valid;
  logic acc_sel_zero;
  logic add_valid_in;
  logic psum_wr_en;
  logic out_valid;
  logic err;

  modport master (
    output start,
    output in_valid,
    output psum_empty,
    output add_valid_in,
    input  busy,
    input  done,
    input  in_ready,
    input  psum_rd_en,
    input  acc_valid,
    input  acc_sel_zero,
    input  psum_wr_en,
    input  out_valid,
    input  err
  );

  modport slave (
    input  start,
    input  in_valid,
    input  psum_empty,
    input  add_valid_in,
    output busy,
    output done,
    output in_ready,
    output psum_rd_en,
    output acc_valid,
    output acc_sel_zero,
    output psum_wr_en,
    output out_valid,
    output err
  );
endinterface

// File: rtl/conv_channel_in_acc_ctrl.sv
// conv_channel_in_acc_ctrl: issue/result sequencing for the
// channel-input accumulation datapath (adder + partial-sum FIFO).
module conv_channel_in_acc_ctrl #(
  parameter int IMAGE_SIZE           = 256,
  parameter int CHANNEL_NUM_IN       = 128,
  parameter int RD_LATENCY           = 2,
  parameter int POINTER_WIDTH        = $clog2(IMAGE_SIZE) + 1,
  parameter int CNT_CHANNEL_IN_WIDTH = $clog2(CHANNEL_NUM_IN) + 1
) (
  input logic clk,
  input logic reset,
  conv_channel_in_acc_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int PW = POINTER_WIDTH;
  localparam int CW = CNT_CHANNEL_IN_WIDTH;

  localparam logic [PW-1:0] PXL_LAST = PW'(IMAGE_SIZE - 1);
  localparam logic [PW-1:0] PXL_ONE  = PW'(1);
  localparam logic [CW-1:0] CH_LAST  = CW'(CHANNEL_NUM_IN - 1);
  localparam logic [CW-1:0] CH_ONE   = CW'(1);

  state_t state;
  state_t state_n;

  logic [PW-1:0] iss_pxl;
  logic [PW-1:0] res_pxl;
  logic [CW-1:0] iss_ch;
  logic [CW-1:0] res_ch;

  logic [RD_LATENCY-1:0] sh_v;
  logic [RD_LATENCY-1:0] sh_z;

  logic busy_q;
  logic done_q;
  logic err_q;

  logic ready;
  logic accept;
  logic take;
  logic last_beat;
  logic last_res;
  logic clear;

  // handshake strobes and next-state selection
  always_comb begin
    state_n   = state;
    clear     = 1'b0;
    ready     = (state == RUN) &&
                ((iss_ch == '0) || !bus.psum_empty);
    accept    = bus.in_valid && ready;
    take      = bus.add_valid_in && (state != IDLE);
    last_beat = accept &&
                (iss_pxl == PXL_LAST) &&
                (iss_ch == CH_LAST);
    last_res  = take &&
                (res_pxl == PXL_LAST) &&
                (res_ch == CH_LAST);
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_n = RUN;
          clear   = 1'b1;
        end
      end
      RUN: begin
        if (last_beat) state_n = DRAIN;
      end
      DRAIN: begin
        if (last_res) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // issue and result pixel/channel counters
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      iss_pxl <= '0;
      iss_ch  <= '0;
      res_pxl <= '0;
      res_ch  <= '0;
    end else begin
      if (accept) begin
        if (iss_pxl == PXL_LAST) begin
          iss_pxl <= '0;
          iss_ch  <= iss_ch + CH_ONE;
        end else begin
          iss_pxl <= iss_pxl + PXL_ONE;
        end
      end
      if (take) begin
        if (res_pxl == PXL_LAST) begin
          res_pxl <= '0;
          res_ch  <= res_ch + CH_ONE;
        end else begin
          res_pxl <= res_pxl + PXL_ONE;
        end
      end
    end
  end

  // align {valid, sel_zero} with the psum read-back latency
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_v <= '0;
      sh_z <= '0;
    end else begin
      sh_v[0] <= accept;
      sh_z[0] <= accept && (iss_ch == '0);
      for (int i = 1; i < RD_LATENCY; i++) begin
        sh_v[i] <= sh_v[i-1];
        sh_z[i] <= sh_z[i-1];
      end
    end
  end

  // busy, completion pulse and sticky protocol error
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= (state_n != IDLE);
      done_q <= last_res;
      err_q  <= err_q ||
                (bus.add_valid_in && (state == IDLE));
    end
  end

  assign bus.in_ready     = ready;
  assign bus.psum_rd_en   = accept && (iss_ch != '0);
  assign bus.psum_wr_en   = take && (res_ch != CH_LAST);
  assign bus.out_valid    = take && (res_ch == CH_LAST);
  assign bus.acc_valid    = sh_v[RD_LATENCY-1];
  assign bus.acc_sel_zero = sh_z[RD_LATENCY-1];
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.err          = err_q;

endmodule

// File: tb/tb_conv_channel_in_acc_ctrl.sv
// tb_conv_channel_in_acc_ctrl: randomized bench with a transaction
// model of the psum FIFO and an in-order variable-latency adder.
module tb_conv_channel_in_acc_ctrl;

  localparam int IS  = 4;
  localparam int CH  = 3;
  localparam int RDL = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  conv_channel_in_acc_ctrl_if a_if ();
  conv_channel_in_acc_ctrl_if b_if ();

  conv_channel_in_acc_ctrl #(
    .IMAGE_SIZE     (IS),
    .CHANNEL_NUM_IN (CH),
    .RD_LATENCY     (RDL)
  ) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (a_if.slave)
  );

  conv_channel_in_acc_ctrl #(
    .IMAGE_SIZE     (IS),
    .CHANNEL_NUM_IN (1),
    .RD_LATENCY     (RDL)
  ) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (b_if.slave)
  );

  int checks   = 0;
  int failures = 0;

  int cyc  = 0;
  int cycb = 0;

  bit src_en    = 1'b1;
  int gap_pct   = 0;
  int lat_min   = 5;
  int lat_max   = 5;
  bit stall_req = 1'b0;
  int force_cnt = 0;
  bit stray     = 1'b0;

  int n_accept, n_rd, n_acc, n_selz, selz_first;
  int n_wr, n_out, n_done;
  int stall_viol, stall_cyc, order_viol, flag_viol;
  int stray_viol, busy_viol, wr_after_out;
  int done_cyc, last_out_cyc;
  int exp_sum [IS];
  int out_q   [$];
  int fifo    [$];
  int op_q    [$];
  int beat_q  [$];
  int res_q   [$];
  int due_q   [$];
  int last_due = 0;

  int b_acc = 0, b_rd = 0, b_av = 0, b_sz = 0;
  int b_out = 0, b_wr = 0, b_done = 0;

  // environment for dut_a: upstream source, psum FIFO, adder
  initial begin
    int v, op, due;
    forever begin
      @(negedge clk);
      if (reset) begin
        fifo.delete();
        op_q.delete();
        beat_q.delete();
        res_q.delete();
        due_q.delete();
        last_due  = 0;
        force_cnt = 0;
      end
      a_if.in_valid = src_en &&
        (int'($urandom_range(99)) >= gap_pct);
      a_if.psum_empty = (fifo.size() == 0) || (force_cnt > 0);
      a_if.add_valid_in = !reset && (stray ||
        (due_q.size() > 0 && due_q[0] == cyc));
      #1;
      if (!reset) begin
        if (force_cnt > 0) begin
          stall_cyc++;
          if (a_if.in_ready) stall_viol++;
          force_cnt--;
        end
        if (a_if.in_valid && a_if.in_ready) begin
          v = int'($urandom_range(1000));
          beat_q.push_back(v);
          exp_sum[n_accept % IS] += v;
          n_accept++;
          if (stall_req && n_accept == IS) begin
            force_cnt = 10;
            stall_req = 1'b0;
          end
        end
        if (a_if.psum_rd_en) begin
          n_rd++;
          if (fifo.size() > 0) op_q.push_back(fifo.pop_front());
          else order_viol++;
        end
        if (a_if.acc_valid) begin
          n_acc++;
          if (a_if.acc_sel_zero) begin
            n_selz++;
            if (n_acc <= IS) selz_first++;
            op = 0;
          end else if (op_q.size() > 0) begin
            op = op_q.pop_front();
          end else begin
            op = 0;
            order_viol++;
          end
          if (beat_q.size() > 0) v = beat_q.pop_front();
          else begin
            v = 0;
            order_viol++;
          end
          due = cyc + int'($urandom_range(lat_max, lat_min));
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          res_q.push_back(op + v);
          due_q.push_back(due);
        end
        if (a_if.add_valid_in && stray) begin
          if (a_if.psum_wr_en || a_if.out_valid) stray_viol++;
        end else if (a_if.add_valid_in) begin
          v = res_q.pop_front();
          void'(due_q.pop_front());
          if (a_if.psum_wr_en == a_if.out_valid) flag_viol++;
          if (a_if.psum_wr_en) begin
            n_wr++;
            fifo.push_back(v);
            if (n_out > 0) wr_after_out++;
          end
          if (a_if.out_valid) begin
            n_out++;
            out_q.push_back(v);
            last_out_cyc = cyc;
          end
        end
        if (a_if.done) begin
          n_done++;
          done_cyc = cyc;
          if (a_if.busy) busy_viol++;
        end
      end
      cyc++;
    end
  end

  // environment for dut_b: single channel, fixed 3-cycle adder
  initial begin
    int bd [$];
    forever begin
      @(negedge clk);
      if (reset) bd.delete();
      b_if.in_valid     = 1'b1;
      b_if.psum_empty   = 1'b1;
      b_if.add_valid_in = !reset &&
        bd.size() > 0 && bd[0] == cycb;
      #1;
      if (!reset) begin
        if (b_if.in_valid && b_if.in_ready) b_acc++;
        if (b_if.psum_rd_en) b_rd++;
        if (b_if.acc_valid) begin
          b_av++;
          if (b_if.acc_sel_zero) b_sz++;
          bd.push_back(cycb + 3);
        end
        if (b_if.add_valid_in) begin
          void'(bd.pop_front());
          if (b_if.out_valid) b_out++;
          if (b_if.psum_wr_en) b_wr++;
        end
        if (b_if.done) b_done++;
      end
      cycb++;
    end
  end

  task automatic clear_stats();
    n_accept = 0; n_rd = 0; n_acc = 0; n_selz = 0;
    selz_first = 0; n_wr = 0; n_out = 0; n_done = 0;
    stall_viol = 0; stall_cyc = 0; order_viol = 0;
    flag_viol = 0; stray_viol = 0; busy_viol = 0;
    wr_after_out = 0; done_cyc = -1; last_out_cyc = -100;
    out_q.delete();
    foreach (exp_sum[i]) exp_sum[i] = 0;
  endtask

  // call at a rising edge; start is seen at the next one
  task automatic pulse_start();
    #2 a_if.start = 1'b1;
    @(posedge clk);
    #2 a_if.start = 1'b0;
  endtask

  task automatic wait_done(input int extra, output bit to);
    to = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      if (n_done > 0) begin
        to = 1'b0;
        break;
      end
    end
    repeat (extra) @(posedge clk);
  endtask

  task automatic test_reset();
    logic [9:0] o;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    o = {a_if.busy, a_if.done, a_if.err, a_if.in_ready,
         a_if.psum_rd_en, a_if.acc_valid, a_if.acc_sel_zero,
         a_if.psum_wr_en, a_if.out_valid, b_if.busy};
    checks++;
    if (o !== 10'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=0", o);
    end
    checks++;
    if (a_if.in_valid !== 1'b1 || a_if.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_in_ready got=%b want=0", a_if.in_ready);
    end
    #1 reset = 1'b0;
  endtask

  task automatic test_basic();
    bit to;
    int got;
    clear_stats();
    @(posedge clk);
    pulse_start();
    wait_done(5, to);
    checks++;
    if (to !== 1'b0) begin
      failures++;
      $display("FAIL basic_timeout got=%0d want=0", to);
    end
    checks++;
    if (n_accept !== IS * CH) begin
      failures++;
      $display("FAIL basic_accepts got=%0d want=%0d", n_accept, IS*CH);
    end
    checks++;
    if (n_rd !== IS * (CH - 1)) begin
      failures++;
      $display("FAIL basic_rd got=%0d want=%0d", n_rd, IS*(CH-1));
    end
    checks++;
    if (n_acc !== IS * CH) begin
      failures++;
      $display("FAIL basic_acc got=%0d want=%0d", n_acc, IS*CH);
    end
    checks++;
    if (selz_first !== IS || n_selz !== IS) begin
      failures++;
      $display("FAIL basic_selz got=%0d/%0d want=%0d/%0d",
               selz_first, n_selz, IS, IS);
    end
    checks++;
    if (n_wr !== IS * (CH - 1) || wr_after_out !== 0) begin
      failures++;
      $display("FAIL basic_wr got=%0d late=%0d want=%0d late=0",
               n_wr, wr_after_out, IS*(CH-1));
    end
    checks++;
    if (n_out !== IS) begin
      failures++;
      $display("FAIL basic_out got=%0d want=%0d", n_out, IS);
    end
    for (int i = 0; i < IS; i++) begin
      got = (i < out_q.size()) ? out_q[i] : -1;
      checks++;
      if (got !== exp_sum[i]) begin
        failures++;
        $display("FAIL basic_sum%0d got=%0d want=%0d",
                 i, got, exp_sum[i]);
      end
    end
    checks++;
    if (n_done !== 1 || done_cyc !== last_out_cyc + 1) begin
      failures++;
      $display("FAIL basic_done got=%0d@%0d want=1@%0d",
               n_done, done_cyc, last_out_cyc + 1);
    end
    checks++;
    if (a_if.busy !== 1'b0 || busy_viol !== 0) begin
      failures++;
      $display("FAIL basic_busy got=%b/%0d want=0/0",
               a_if.busy, busy_viol);
    end
    checks++;
    if (a_if.err !== 1'b0 || order_viol !== 0 || flag_viol !== 0) begin
      failures++;
      $display("FAIL basic_proto got=%b/%0d/%0d want=0/0/0",
               a_if.err, order_viol, flag_viol);
    end
  endtask

  task automatic test_stall();
    bit to;
    int got;
    clear_stats();
    stall_req = 1'b1;
    @(posedge clk);
    pulse_start();
    wait_done(5, to);
    checks++;
    if (to !== 1'b0) begin
      failures++;
      $display("FAIL stall_timeout got=%0d want=0", to);
    end
    checks++;
    if (stall_cyc !== 10 || stall_viol !== 0) begin
      failures++;
      $display("FAIL stall_ready got=%0d/%0d want=10/0",
               stall_cyc, stall_viol);
    end
    checks++;
    if (n_accept !== IS*CH || n_rd !== IS*(CH-1) ||
        n_wr !== IS*(CH-1) || n_out !== IS) begin
      failures++;
      $display("FAIL stall_counts got=%0d/%0d/%0d/%0d want=%0d/%0d/%0d/%0d",
               n_accept, n_rd, n_wr, n_out,
               IS*CH, IS*(CH-1), IS*(CH-1), IS);
    end
    for (int i = 0; i < IS; i++) begin
      got = (i < out_q.size()) ? out_q[i] : -1;
      checks++;
      if (got !== exp_sum[i]) begin
        failures++;
        $display("FAIL stall_sum%0d got=%0d want=%0d",
                 i, got, exp_sum[i]);
      end
    end
    checks++;
    if (n_done !== 1 || order_viol !== 0) begin
      failures++;
      $display("FAIL stall_done got=%0d/%0d want=1/0",
               n_done, order_viol);
    end
  endtask

  task automatic test_start_during_run();
    bit to;
    clear_stats();
    @(posedge clk);
    pulse_start();
    repeat (4) @(posedge clk);
    #2 a_if.start = 1'b1;
    @(posedge clk);
    #2 a_if.start = 1'b0;
    wait_done(5, to);
    checks++;
    if (to !== 1'b0 || n_done !== 1) begin
      failures++;
      $display("FAIL rerun_done got=%0d/%0d want=0/1", to, n_done);
    end
    checks++;
    if (n_accept !== IS * CH || n_out !== IS) begin
      failures++;
      $display("FAIL rerun_counts got=%0d/%0d want=%0d/%0d",
               n_accept, n_out, IS*CH, IS);
    end
  endtask

  task automatic test_stray_err();
    int w0, o0;
    @(posedge clk);
    #2;
    w0 = n_wr;
    o0 = n_out;
    stray = 1'b1;
    @(posedge clk);
    #2 stray = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (a_if.err !== 1'b1) begin
      failures++;
      $display("FAIL stray_err got=%b want=1", a_if.err);
    end
    checks++;
    if (stray_viol !== 0 || n_wr !== w0 || n_out !== o0) begin
      failures++;
      $display("FAIL stray_effect got=%0d want=0", stray_viol);
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (a_if.err !== 1'b1 || a_if.busy !== 1'b0) begin
      failures++;
      $display("FAIL stray_sticky got=%b/%b want=1/0",
               a_if.err, a_if.busy);
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    int got;
    logic [8:0] o;
    clear_stats();
    @(posedge clk);
    pulse_start();
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      if (n_accept > IS) break;
    end
    checks++;
    if (n_accept <= IS) begin
      failures++;
      $display("FAIL rmid_reach got=%0d want>%0d", n_accept, IS);
    end
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    o = {a_if.busy, a_if.done, a_if.err, a_if.in_ready,
         a_if.psum_rd_en, a_if.acc_valid, a_if.acc_sel_zero,
         a_if.psum_wr_en, a_if.out_valid};
    checks++;
    if (o !== 9'b0) begin
      failures++;
      $display("FAIL rmid_outputs got=%b want=0", o);
    end
    #1 reset = 1'b0;
    @(posedge clk);
    clear_stats();
    @(posedge clk);
    pulse_start();
    wait_done(5, to);
    checks++;
    if (to !== 1'b0 || n_done !== 1) begin
      failures++;
      $display("FAIL rmid_done got=%0d/%0d want=0/1", to, n_done);
    end
    checks++;
    if (n_accept !== IS*CH || n_rd !== IS*(CH-1) ||
        n_out !== IS || n_selz !== IS) begin
      failures++;
      $display("FAIL rmid_counts got=%0d/%0d/%0d/%0d",
               n_accept, n_rd, n_out, n_selz);
    end
    for (int i = 0; i < IS; i++) begin
      got = (i < out_q.size()) ? out_q[i] : -1;
      checks++;
      if (got !== exp_sum[i]) begin
        failures++;
        $display("FAIL rmid_sum%0d got=%0d want=%0d",
                 i, got, exp_sum[i]);
      end
    end
    checks++;
    if (a_if.err !== 1'b0) begin
      failures++;
      $display("FAIL rmid_err got=%b want=0", a_if.err);
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    int got;
    gap_pct = 30;
    lat_min = 3;
    lat_max = 9;
    @(posedge clk);
    for (int p = 0; p < 3; p++) begin
      clear_stats();
      pulse_start();
      wait_done(0, to);
      checks++;
      if (to !== 1'b0 || n_done !== 1) begin
        failures++;
        $display("FAIL b2b%0d_done got=%0d/%0d want=0/1",
                 p, to, n_done);
      end
      checks++;
      if (n_out !== IS || n_accept !== IS * CH) begin
        failures++;
        $display("FAIL b2b%0d_out got=%0d/%0d want=%0d/%0d",
                 p, n_out, n_accept, IS, IS*CH);
      end
      for (int i = 0; i < IS; i++) begin
        got = (i < out_q.size()) ? out_q[i] : -1;
        checks++;
        if (got !== exp_sum[i]) begin
          failures++;
          $display("FAIL b2b%0d_sum%0d got=%0d want=%0d",
                   p, i, got, exp_sum[i]);
        end
      end
      checks++;
      if (a_if.err !== 1'b0 || order_viol !== 0 ||
          flag_viol !== 0) begin
        failures++;
        $display("FAIL b2b%0d_proto got=%b/%0d/%0d want=0/0/0",
                 p, a_if.err, order_viol, flag_viol);
      end
    end
    repeat (5) @(posedge clk);
    gap_pct = 0;
    lat_min = 5;
    lat_max = 5;
  endtask

  task automatic test_single_channel();
    @(posedge clk);
    #2 b_if.start = 1'b1;
    @(posedge clk);
    #2 b_if.start = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      if (b_done > 0) break;
    end
    repeat (5) @(posedge clk);
    checks++;
    if (b_av !== IS || b_sz !== IS || b_acc !== IS) begin
      failures++;
      $display("FAIL ch1_acc got=%0d/%0d/%0d want=%0d/%0d/%0d",
               b_av, b_sz, b_acc, IS, IS, IS);
    end
    checks++;
    if (b_rd !== 0 || b_wr !== 0) begin
      failures++;
      $display("FAIL ch1_fifo got=%0d/%0d want=0/0", b_rd, b_wr);
    end
    checks++;
    if (b_out !== IS || b_done !== 1) begin
      failures++;
      $display("FAIL ch1_out got=%0d/%0d want=%0d/1",
               b_out, b_done, IS);
    end
  endtask

  initial begin
    a_if.start = 1'b0;
    b_if.start = 1'b0;
    a_if.in_valid = 1'b0;
    a_if.psum_empty = 1'b1;
    a_if.add_valid_in = 1'b0;
    b_if.in_valid = 1'b0;
    b_if.psum_empty = 1'b1;
    b_if.add_valid_in = 1'b0;
    clear_stats();
    test_reset();
    test_basic();
    test_stall();
    test_start_during_run();
    test_stray_err();
    test_reset_mid();
    test_back_to_back();
    test_single_channel();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_channel_in_acc_ctrl.md
# conv_channel_in_acc_ctrl

Sequencing controller for the channel-input accumulation datapath (fp adder plus partial-sum FIFO). It accepts a stream of per-pixel products plane by plane, one input channel per plane. It decides per beat whether the adder operand is zero (first channel) or a read-back partial sum. On the adder side it steers each result to the partial-sum FIFO or to the block output (last channel), then signals completion. One controller instance serves one output channel of a conv layer.

## Interface
- IMAGE_SIZE, 256: pixels per channel plane.
- CHANNEL_NUM_IN, 128: input channels accumulated per output pixel (≥1).
- RD_LATENCY, 2: cycles from psum_rd_en to the partial sum being valid at the adder operand (≥1).
- POINTER_WIDTH, $clog2(IMAGE_SIZE)+1: pixel counter width.
- CNT_CHANNEL_IN_WIDTH, $clog2(CHANNEL_NUM_IN)+1: channel counter width.

- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  pulse; begins one accumulation pass; honoured only in IDLE.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse after the final output result.
- in_valid  in  1  upstream product beat valid.
- in_ready  out  1  controller accepts the beat (combinational).
- psum_empty  in  1  partial-sum FIFO empty.
- psum_rd_en  out  1  partial-sum FIFO read strobe.
- acc_valid  out  1  adder input valid, aligned to the operand.
- acc_sel_zero  out  1  select 0.0 as the adder second operand.
- add_valid_in  in  1  adder result valid.
- psum_wr_en  out  1  write the adder result to the partial-sum FIFO.
- out_valid  out  1  the adder result is a final output pixel.
- err  out  1  sticky protocol error.

## Operation
- States: IDLE, RUN, DRAIN.
  - IDLE→RUN on start. All counters clear.
  - RUN→DRAIN when the last beat (pixel IMAGE_SIZE-1, channel CHANNEL_NUM_IN-1) is accepted.
  - DRAIN→IDLE when the last result is consumed. done pulses the next cycle.
- Issue counters iss_pxl (0..IMAGE_SIZE-1) and iss_ch (0..CHANNEL_NUM_IN-1) advance on each accepted beat (in_valid & in_ready). iss_pxl wraps to 0 and increments iss_ch.
- in_ready = RUN & (iss_ch==0 | !psum_empty). Channel 0 never stalls. Later channels stall while the FIFO is empty.
- psum_rd_en = accepted beat & iss_ch≠0.
- Result counters res_pxl and res_ch advance on add_valid_in with the same wrap rule.
  - psum_wr_en = add_valid_in & res_ch≠CHANNEL_NUM_IN-1.
  - out_valid = add_valid_in & res_ch==CHANNEL_NUM_IN-1.
- CHANNEL_NUM_IN==1: every beat has sel_zero=1 and no FIFO reads. Every result is out_valid; psum_wr_en is never asserted.
- start while busy is ignored. add_valid_in in IDLE, or after the last result, sets err and has no other effect. err clears only on reset.
- Reset at any point: state IDLE, all counters 0, shift register cleared. All outputs 0, except in_ready=0.

## Timing
- Accept → acc_valid: exactly RD_LATENCY cycles, through a RD_LATENCY-deep shift register of {valid, sel_zero}. acc_sel_zero is 1 iff the beat had iss_ch==0.
- psum_rd_en is asserted in the same cycle as acceptance.
- in_ready, psum_rd_en, psum_wr_en and out_valid are combinational. acc_valid, acc_sel_zero, busy, done and err are registered.
- done: registered one cycle after the final out_valid. busy falls in the same cycle done rises.
- Back-to-back passes: start is accepted the cycle after done at the earliest.
- Adder latency is not a parameter: results are matched by order, so any fixed or variable latency is valid.

## Test plan
- IMAGE_SIZE=4, CHANNEL_NUM_IN=3, RD_LATENCY=2, in_valid held high, FIFO model with 5-cycle adder:
  - Expect 12 accepts and 8 psum_rd_en.
  - acc_sel_zero=1 on exactly the first 4 acc_valid.
  - 8 psum_wr_en, then 4 out_valid.
  - One done pulse; busy low afterwards.
- Same config, psum_empty forced high for 10 cycles at the start of channel 1: in_ready=0 throughout the stall. No beat is lost or duplicated, and the counts match the first scenario.
- CHANNEL_NUM_IN=1, IMAGE_SIZE=4: 4 acc_valid all with sel_zero=1, psum_rd_en never asserted, 4 out_valid, done.
- start pulsed during RUN: no effect. A stray add_valid_in in IDLE: err=1 and stays 1.
- reset asserted mid-channel-1: the next cycle all outputs are 0 and the state is IDLE. A new start then completes a full pass correctly.
- Random in_valid gaps (30%) and random adder latency 3–9 cycles with in-order results: out_valid count = IMAGE_SIZE per pass, no err.
